alu_seq_param: RTL

Parametrised, handshaked successor to the fixed 8-bit top-level ALU. It accepts an operand pair and a one-hot operation, then executes it. Single-cycle ops take one EXEC cycle; multiply is a WIDTH-cycle shift-add. The result is held until the consumer takes it. An internal accumulator supports chained (persist) operation. State is exported for bench and debug visibility.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_mul_seq.sv | 58 +++++
 rtl/alu_seq_param.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: FSM states, op/in_sel one-hot bit
// indices and flag bit positions.
package alu_pkg;

    localparam int unsigned OP_W  = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned FLG_W = 4;
    localparam int unsigned ST_W  = 2;

    typedef enum logic [ST_W-1:0] {
        ST_OFF  = 2'b00,
        ST_IDLE = 2'b01,
        ST_EXEC = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // op_sel one-hot bit positions (bit7 = ADD)
    localparam int unsigned OP_ADD = 7;
    localparam int unsigned OP_SUB = 6;
    localparam int unsigned OP_AND = 5;
    localparam int unsigned OP_OR  = 4;
    localparam int unsigned OP_XOR = 3;
    localparam int unsigned OP_SHL = 2;
    localparam int unsigned OP_SHR = 1;
    localparam int unsigned OP_MUL = 0;

    // in_sel one-hot bit positions {persist, load, clear}
    localparam int unsigned SEL_PERSIST = 2;
    localparam int unsigned SEL_LOAD    = 1;
    localparam int unsigned SEL_CLEAR   = 0;

    // flags bit positions {carry, zero, overflow, err}
    localparam int unsigned FLG_CARRY = 3;
    localparam int unsigned FLG_ZERO  = 2;
    localparam int unsigned FLG_OVF   = 1;
    localparam int unsigned FLG_ERR   = 0;

    function automatic logic is_onehot(input logic [OP_W-1:0] v);
        return (v != '0) && ((v & (v - OP_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier. The start edge already folds in
// bit 0 of b; done is raised once all WIDTH partial products are summed.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [PW-1:0]    r_prod;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             w_last;

    assign w_last  = (r_cnt == CW'(WIDTH));
    assign busy    = r_busy;
    assign done    = r_busy && w_last;
    assign product = r_prod;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_prod   <= b[0] ? PW'(a) : '0;
            r_mcand  <= PW'(a) << 1;
            r_mplier <= b >> 1;
            r_cnt    <= CW'(1);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (w_last) begin
                r_busy <= 1'b0;
            end else begin
                if (r_mplier[0]) begin
                    r_prod <= r_prod + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq_param.sv
// Handshaked sequential ALU: control FSM, accumulator and single-cycle datapath;
// MUL runs on alu_mul_seq. Build option ALU_SAT_EN saturates ADD/SUB.
module alu_seq_param
    import alu_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [OP_W-1:0]  op_sel,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FLG_W-1:0] flags,
    output logic [ST_W-1:0]  curr_state,
    output logic [ST_W-1:0]  next_state
);

    localparam int unsigned DW  = 2 * WIDTH;
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    state_e           r_state;
    state_e           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OP_W-1:0]  r_op;
    logic             r_is_mul;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_out;
    logic [FLG_W-1:0] r_flags;
    logic             r_out_valid;

    logic             w_xfer;
    logic             w_clear;
    logic             w_load;
    logic             w_in_mul;
    logic             w_mul_start;
    logic [WIDTH-1:0] w_opa;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic             w_mul_fin;
    logic [DW-1:0]    w_prod;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_amt;
    logic [DW-1:0]    w_shl;
    logic [DW-1:0]    w_shr;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_err;
    logic [FLG_W-1:0] w_flags;

    assign in_ready   = (r_state == ST_IDLE) && on;
    assign out        = r_out;
    assign out_valid  = r_out_valid;
    assign flags      = r_flags;
    assign curr_state = r_state;
    assign next_state = w_next;

    // Transfer decode; clear beats load beats persist, and no bits set means load
    assign w_xfer      = in_valid && in_ready;
    assign w_clear     = in_sel[SEL_CLEAR];
    assign w_load      = in_sel[SEL_LOAD] || !in_sel[SEL_PERSIST];
    assign w_in_mul    = is_onehot(op_sel) && op_sel[OP_MUL];
    assign w_mul_start = w_xfer && !w_clear && w_in_mul;
    assign w_opa       = w_load ? num1 : r_acc;
    assign w_mul_fin   = w_mul_busy && w_mul_done;

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (w_opa),
        .b       (num2),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_prod)
    );

    // Next-state logic; dropping on overrides every other transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_OFF:  w_next = ST_IDLE;
            ST_IDLE: if (w_xfer && !w_clear) w_next = ST_EXEC;
            ST_EXEC: if (!r_is_mul || w_mul_fin) w_next = ST_DONE;
            ST_DONE: if (r_out_valid && out_ready) w_next = ST_IDLE;
            default: w_next = ST_OFF;
        endcase
        if (!on) begin
            w_next = ST_OFF;
        end
    end

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};
    assign w_amt  = r_b[SHW-1:0];
    assign w_shl  = DW'(r_a) << w_amt;
    assign w_shr  = {r_a, {WIDTH{1'b0}}} >> w_amt;

    // Result and carry/overflow for the captured operation
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        if (r_is_mul) begin
            w_res = w_prod[WIDTH-1:0];
            w_ovf = |w_prod[DW-1:WIDTH];
        end else if (!is_onehot(r_op)) begin
            w_err = 1'b1;
        end else if (r_op[OP_ADD]) begin
            w_res   = w_sum[WIDTH-1:0];
            w_carry = w_sum[WIDTH];
            w_ovf   = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
`ifdef ALU_SAT_EN
            if (w_sum[WIDTH]) w_res = '1;
`endif
        end else if (r_op[OP_SUB]) begin
            w_res   = w_diff[WIDTH-1:0];
            w_carry = w_diff[WIDTH];
            w_ovf   = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
`ifdef ALU_SAT_EN
            if (w_diff[WIDTH]) w_res = '0;
`endif
        end else if (r_op[OP_AND]) begin
            w_res = r_a & r_b;
        end else if (r_op[OP_OR]) begin
            w_res = r_a | r_b;
        end else if (r_op[OP_XOR]) begin
            w_res = r_a ^ r_b;
        end else if (r_op[OP_SHL]) begin
            w_res   = w_shl[WIDTH-1:0];
            w_carry = w_shl[WIDTH];
        end else if (r_op[OP_SHR]) begin
            w_res   = w_shr[DW-1:WIDTH];
            w_carry = w_shr[WIDTH-1];
        end
    end

    always_comb begin
        w_flags            = '0;
        w_flags[FLG_CARRY] = w_carry;
        w_flags[FLG_ZERO]  = (w_res == '0);
        w_flags[FLG_OVF]   = w_ovf;
        w_flags[FLG_ERR]   = w_err;
    end

    // State, operand capture, result/flag registers and accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_OFF;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_is_mul    <= 1'b0;
            r_acc       <= ACC_INIT;
            r_out       <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_out_valid <= (w_next == ST_DONE);
            if (on) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_xfer) begin
                            if (w_clear) begin
                                r_acc   <= ACC_INIT;
                                r_out   <= '0;
                                r_flags <= '0;
                            end else begin
                                r_a      <= w_opa;
                                r_b      <= num2;
                                r_op     <= op_sel;
                                r_is_mul <= w_in_mul;
                            end
                        end
                    end
                    ST_EXEC: begin
                        if (!r_is_mul || w_mul_fin) begin
                            r_out   <= w_res;
                            r_flags <= w_flags;
                            if (!w_err) begin
                                r_acc <= w_res;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
